// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with bus lock for a single-port sync memory
// Optional lock-hold timeout is enabled by defining ARB_LOCK_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_SIZE    = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_lock,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    input  logic                 m1_req,
    input  logic                 m1_lock,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic                 m0_ack,
    output logic                 m1_ack,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 lock_timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

    state_t r_state;
    logic   r_last_gnt;     // 0 = m0, 1 = m1
    logic   r_cur;          // master owning the in-flight access
    logic   r_owner_vld;
    logic   r_owner;

    logic   w_arb;
    logic   w_req0;
    logic   w_req1;
    logic   w_own_lock;
    logic   w_timeout_hit;
    logic   w_revoke;
    logic   w_own_keep;
    logic   w_elig0;
    logic   w_elig1;
    logic   w_win_vld;
    logic   w_win;
    logic   w_win_lock;

    // In DONE the master just acked is masked so the other side gets a turn.
    always_comb begin
        w_arb      = (r_state == IDLE) || (r_state == DONE);
        w_req0     = m0_req && !((r_state == DONE) && !r_cur);
        w_req1     = m1_req && !((r_state == DONE) &&  r_cur);
        w_own_lock = r_owner ? m1_lock : m0_lock;
        w_revoke   = w_arb && w_timeout_hit && (r_owner ? m0_req : m1_req);
        w_own_keep = r_owner_vld && w_own_lock && !w_revoke;
        w_elig0    = w_req0 && (!w_own_keep || !r_owner);
        w_elig1    = w_req1 && (!w_own_keep ||  r_owner);
        w_win_vld  = 1'b0;
        w_win      = 1'b0;
        if (w_revoke) begin
            w_win_vld = 1'b1;
            w_win     = !r_owner;
        end else if (w_elig0 && w_elig1) begin
            w_win_vld = 1'b1;
            w_win     = !r_last_gnt;
        end else begin
            w_win_vld = w_elig0 || w_elig1;
            w_win     = w_elig1;
        end
        w_win_lock = w_win ? m1_lock : m0_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_cur       <= 1'b0;
            r_owner_vld <= 1'b0;
            r_owner     <= 1'b0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            rdata       <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            mem_en <= 1'b0;
            if (w_arb) begin
                if (w_win_vld) begin
                    r_owner_vld <= w_win_lock;
                    r_owner     <= w_win;
                    r_cur       <= w_win;
                    r_last_gnt  <= w_win;
                    m0_gnt      <= !w_win;
                    m1_gnt      <= w_win;
                    mem_en      <= 1'b1;
                    mem_we      <= w_win ? m1_we    : m0_we;
                    mem_addr    <= w_win ? m1_addr  : m0_addr;
                    mem_wdata   <= w_win ? m1_wdata : m0_wdata;
                    r_state     <= ACCESS;
                end else begin
                    r_owner_vld <= w_own_keep;
                    m0_gnt      <= 1'b0;
                    m1_gnt      <= 1'b0;
                    r_state     <= IDLE;
                end
            end else if (r_state == ACCESS) begin
                r_state <= RESP;
            end else begin
                // Memory data for the ACCESS cycle is valid now.
                if (!mem_we) begin
                    rdata <= mem_rdata;
                end
                m0_ack  <= !r_cur;
                m1_ack  <= r_cur;
                r_state <= DONE;
            end
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT);

    logic [CW-1:0] r_lock_cnt;
    logic          w_cnt_clr;

    assign w_timeout_hit = r_owner_vld && w_own_lock && (r_lock_cnt >= CNT_MAX);
    assign w_cnt_clr     = w_arb && (w_win_vld ? (!w_win_lock || !r_owner_vld || (w_win != r_owner))
                                               : !w_own_keep);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_cnt   <= '0;
            lock_timeout <= 1'b0;
        end else begin
            if (w_revoke) begin
                lock_timeout <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_lock_cnt <= '0;
            end else if (r_owner_vld && (r_lock_cnt != CNT_MAX)) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end
`else
    // Without the counter the timeout can never fire.
    assign w_timeout_hit = (LOCK_TIMEOUT < 0);
    assign lock_timeout  = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the single-port synchronous program/data memory.
- Master 0 is the CPU core; master 1 is the boot loader / DMA port.
- Serialises read/write accesses, applies round-robin fairness and a bus lock for burst loads.
- Drives the memory-side address, data and write-enable, and returns read data with a one-cycle ack per access.

Parameters:
- WORD_SIZE, 16, data word width
- ADDR_SIZE, 8, address width
- LOCK_TIMEOUT, 64, maximum lock hold in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  master 0 access request; held until m0_ack
- m0_lock  in  1  master 0 requests exclusive bus ownership
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_SIZE  master 0 address
- m0_wdata  in  WORD_SIZE  master 0 write data
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata  in  same widths as master 0 equivalents  master 1 request set
- m0_gnt, m1_gnt  out  1 each  one-hot grant, registered
- m0_ack, m1_ack  out  1 each  one-cycle access-complete pulse
- rdata  out  WORD_SIZE  registered read data, valid while an ack is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data, valid the cycle after mem_en
- lock_timeout  out  1  sticky lock-timeout flag

Behaviour:
- Reset:
  - All outputs 0, state IDLE, lock owner none.
  - last_gnt = 1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP, DONE.
- IDLE: arbitrate every cycle among eligible requests.
  - On a winner: register mem_addr/mem_we/mem_wdata from that master, set its gnt, update last_gnt, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS: mem_en = 1 for exactly one cycle; go to RESP.
- RESP: mem_en = 0; rdata <= mem_rdata at the end of the cycle (reads only; writes leave rdata unchanged); go to DONE.
- DONE: granted master's ack = 1; gnt stays high through DONE.
  - Arbitrate at the end of DONE with the acked master's req ignored.
  - If the other master is eligible: go directly to ACCESS (back-to-back). Otherwise go to IDLE.
  - gnt clears on leaving DONE.
- Latency: req sampled at edge E; ACCESS is cycle E+1, RESP is E+2, ack is high during E+3. Throughput is one access per 3 cycles under contention.
- Round-robin: when both requests are eligible, grant the master that is not last_gnt.
- Lock:
  - If the winner has lock = 1 at grant, it becomes lock owner.
  - While an owner exists, only the owner is eligible; the other master waits with req held.
  - Ownership clears at any arbitration point where the owner's lock = 0.
  - Owner ownership persists through IDLE with no owner request.
- Late request drop: a request dropped after grant still completes; the memory access and ack both occur.
- Mem outputs: mem_we, mem_addr and mem_wdata hold their values outside ACCESS. mem_we is meaningful only while mem_en = 1.
- Reset mid-operation:
  - The in-flight access is abandoned; no ack is issued.
  - Outputs return to reset values in the next cycle.
  - If rst falls during ACCESS, the memory may already have sampled mem_en; this is accepted.
- Both req low with a lock owner present: stay in IDLE, lock held.

Optional Feature:
Macro ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter runs while a lock owner exists; it clears on owner change or ownership release.
  - When the count reaches LOCK_TIMEOUT at an arbitration point, and the other master is requesting, ownership is revoked and the other master is granted.
  - lock_timeout sets to 1 and stays set until rst.
- Undefined: no counter; lock is held indefinitely; lock_timeout is tied to 0.

Test Plan:
- Single read: m0_req = 1, addr = 0x10, memory holds 0xBEEF -> mem_en high in cycle 1, m0_ack plus rdata = 0xBEEF in cycle 3, m1 signals stay 0.
- Simultaneous requests after reset: m0 write 0x0004 to addr 0x20; m1 read addr 0x30 -> m0 granted first; m1 ACCESS immediately follows m0's DONE; acks 3 cycles apart; the read returns the stored value.
- Continuous contention for 6 accesses -> grants alternate m0, m1, m0, m1...; neither master is granted twice in a row.
- Lock burst: m1_lock = 1 for 4 writes (addr 0x00-0x06) while m0_req = 1 -> all 4 m1 accesses complete first; m0 is granted at the arbitration after m1_lock drops.
- rst asserted in RESP of an m0 read -> no m0_ack; all outputs 0 the next cycle; a fresh request completes normally.
- ARB_LOCK_TIMEOUT_EN, LOCK_TIMEOUT = 8: m1 holds lock with repeated requests and m0 requests -> m0 granted after ≤ 8 owner cycles; lock_timeout = 1 and sticky.
